// File: rtl/id_ex_pipe.sv
// id_ex_pipe : ID/EX pipeline register with load-use hazard detection.
//
// Captures the decode-stage control bits, operands and register indices into
// the EX stage. It also raises hazard_stall, which freezes PC and IF/ID:
//    - when the instruction in EX is a load whose destination feeds the
//      instruction in ID (load-use), or
//    - when the downstream logic is busy (stall_in) and ID holds a real
//      instruction.
//
// Update priority on each clock edge: flush > stall_in > load-use bubble > load.
// A flush or a bubble clears every EX field to zero.
//
// Ports
//    clk, reset                       clock; async active-high reset
//    id_valid, decode controls        Branch..Shift, ALUOp
//    id_pc/rd1/rd2/imm                XLEN-wide data fields
//    id_rs1/rs2/rd, id_funct4         register indices, {instr[30], funct3}
//    flush, stall_in                  kill / hold the EX contents
//    ex_*                             registered copies of the id_* inputs
//    hazard_stall                     combinational freeze request
//
// Optional feature: define ID_EX_PERF_EN to add two 32-bit counters,
// perf_bubbles and perf_flushes. They wrap around and do not advance while
// the stage is held by stall_in.

module id_ex_pipe #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic            Branch,
   input  logic            MemRead,
   input  logic            MemtoReg,
   input  logic            MemWrite,
   input  logic            ALUSrc,
   input  logic            RegWrite,
   input  logic            Shift,
   input  logic [1:0]      ALUOp,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rd1,
   input  logic [XLEN-1:0] id_rd2,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [3:0]      id_funct4,
   input  logic            flush,
   input  logic            stall_in,
   output logic            ex_valid,
   output logic            ex_Branch,
   output logic            ex_MemRead,
   output logic            ex_MemtoReg,
   output logic            ex_MemWrite,
   output logic            ex_ALUSrc,
   output logic            ex_RegWrite,
   output logic            ex_Shift,
   output logic [1:0]      ex_ALUOp,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rd1,
   output logic [XLEN-1:0] ex_rd2,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [3:0]      ex_funct4,
   output logic            hazard_stall
`ifdef ID_EX_PERF_EN
   ,
   output logic [31:0]     perf_bubbles,
   output logic [31:0]     perf_flushes
`endif
);

   typedef struct packed {
      logic            valid;
      logic            branch;
      logic            memread;
      logic            memtoreg;
      logic            memwrite;
      logic            alusrc;
      logic            regwrite;
      logic            shift;
      logic [1:0]      aluop;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [3:0]      funct4;
   } ex_t;

   ex_t  ex_q;
   ex_t  id_d;
   logic id_uses_rs2;
   logic load_use;
   logic bubble;

   // Stores and branches read rs2 even though ALUSrc selects the immediate.
   assign id_uses_rs2 = ~ALUSrc | MemWrite | Branch;

   // ex_q.valid is cleared while reset is high, so this term is already 0
   // during reset.
   assign load_use = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) &
                     ((ex_q.rd == id_rs1) | (id_uses_rs2 & (ex_q.rd == id_rs2)));

   // stall_in is an external input and can be high during reset, so this
   // output is also masked by reset directly.
   assign hazard_stall = ~reset & (load_use | (stall_in & id_valid));

   // A bubble is inserted only when the stage is not already held or flushed.
   assign bubble = load_use & ~stall_in & ~flush;

   // Control bits are qualified by id_valid. Data fields load regardless,
   // because they are ignored whenever valid is 0.
   always_comb begin
      id_d          = '0;
      id_d.valid    = id_valid;
      id_d.branch   = id_valid & Branch;
      id_d.memread  = id_valid & MemRead;
      id_d.memtoreg = id_valid & MemtoReg;
      id_d.memwrite = id_valid & MemWrite;
      id_d.alusrc   = id_valid & ALUSrc;
      id_d.regwrite = id_valid & RegWrite & (id_rd != 5'd0);
      id_d.shift    = id_valid & Shift;
      id_d.aluop    = id_valid ? ALUOp : 2'b00;
      id_d.pc       = id_pc;
      id_d.rd1      = id_rd1;
      id_d.rd2      = id_rd2;
      id_d.imm      = id_imm;
      id_d.rs1      = id_rs1;
      id_d.rs2      = id_rs2;
      id_d.rd       = id_rd;
      id_d.funct4   = id_funct4;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q <= '0;
      end else if (flush || bubble) begin
         ex_q <= '0;
      end else if (!stall_in) begin
         ex_q <= id_d;
      end
   end

   assign ex_valid    = ex_q.valid;
   assign ex_Branch   = ex_q.branch;
   assign ex_MemRead  = ex_q.memread;
   assign ex_MemtoReg = ex_q.memtoreg;
   assign ex_MemWrite = ex_q.memwrite;
   assign ex_ALUSrc   = ex_q.alusrc;
   assign ex_RegWrite = ex_q.regwrite;
   assign ex_Shift    = ex_q.shift;
   assign ex_ALUOp    = ex_q.aluop;
   assign ex_pc       = ex_q.pc;
   assign ex_rd1      = ex_q.rd1;
   assign ex_rd2      = ex_q.rd2;
   assign ex_imm      = ex_q.imm;
   assign ex_rs1      = ex_q.rs1;
   assign ex_rs2      = ex_q.rs2;
   assign ex_rd       = ex_q.rd;
   assign ex_funct4   = ex_q.funct4;

`ifdef ID_EX_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_bubbles <= '0;
         perf_flushes <= '0;
      end else begin
         if (bubble) perf_bubbles <= perf_bubbles + 32'd1;
         if (flush)  perf_flushes <= perf_flushes + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed testbench for id_ex_pipe. Every expected value below is
// hand-computed from the intended pipeline behaviour.
module tb_id_ex_pipe;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic            id_valid;
   logic            Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Shift;
   logic [1:0]      ALUOp;
   logic [XLEN-1:0] id_pc, id_rd1, id_rd2, id_imm;
   logic [4:0]      id_rs1, id_rs2, id_rd;
   logic [3:0]      id_funct4;
   logic            flush, stall_in;
   logic            ex_valid, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite;
   logic            ex_ALUSrc, ex_RegWrite, ex_Shift;
   logic [1:0]      ex_ALUOp;
   logic [XLEN-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]      ex_rs1, ex_rs2, ex_rd;
   logic [3:0]      ex_funct4;
   logic            hazard_stall;
`ifdef ID_EX_PERF_EN
   logic [31:0]     perf_bubbles, perf_flushes;
`endif

   int n_cmp = 0;
   int n_err = 0;

   id_ex_pipe #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
      .ALUSrc(ALUSrc), .RegWrite(RegWrite), .Shift(Shift), .ALUOp(ALUOp),
      .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct4(id_funct4),
      .flush(flush), .stall_in(stall_in),
      .ex_valid(ex_valid), .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead),
      .ex_MemtoReg(ex_MemtoReg), .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc),
      .ex_RegWrite(ex_RegWrite), .ex_Shift(ex_Shift), .ex_ALUOp(ex_ALUOp),
      .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct4(ex_funct4),
      .hazard_stall(hazard_stall)
`ifdef ID_EX_PERF_EN
      , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge, well away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_id();
      id_valid = 0; Branch = 0; MemRead = 0; MemtoReg = 0; MemWrite = 0;
      ALUSrc = 0; RegWrite = 0; Shift = 0; ALUOp = 2'b00;
      id_pc = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_funct4 = 0;
   endtask

   // Instruction shapes (fields not listed stay 0 from clear_id)
   task automatic id_ld(input logic [4:0] rd, input logic [4:0] rs1);
      clear_id(); id_valid = 1; MemRead = 1; MemtoReg = 1; ALUSrc = 1; RegWrite = 1;
      id_rd = rd; id_rs1 = rs1; id_imm = 64'h8; id_pc = 64'h100;
   endtask

   task automatic id_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      clear_id(); id_valid = 1; RegWrite = 1; ALUOp = 2'b10;
      id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_pc = 64'h104;
      id_rd1 = 64'hAAAA; id_rd2 = 64'hBBBB;
   endtask

   task automatic id_sd(input logic [4:0] rs1, input logic [4:0] rs2);
      clear_id(); id_valid = 1; MemWrite = 1; ALUSrc = 1;
      id_rs1 = rs1; id_rs2 = rs2; id_imm = 64'h20; id_pc = 64'h108; id_funct4 = 4'h3;
   endtask

   task automatic id_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [63:0] imm);
      clear_id(); id_valid = 1; ALUSrc = 1; RegWrite = 1; ALUOp = 2'b10;
      id_rd = rd; id_rs1 = rs1; id_imm = imm; id_pc = 64'h10C;
   endtask

   initial begin
      clear_id();
      flush = 0; stall_in = 0; reset = 1;

      // While reset is high, nothing is valid in EX and no stall is requested,
      // even with stall_in and id_valid both high.
      id_valid = 1; stall_in = 1;
      #12;
      check("rst_ex_valid", 64'(ex_valid), 64'd0);
      check("rst_hazard", 64'(hazard_stall), 64'd0);
      check("rst_ex_pc", ex_pc, 64'd0);
      stall_in = 0;

      // Load then use: ld x5 reaches EX, add x7,x5,x6 in ID -> one bubble
      reset = 0;
      id_ld(5'd5, 5'd2);
      tick();
      check("ld_memread", 64'(ex_MemRead), 64'd1);
      check("ld_rd", 64'(ex_rd), 64'd5);
      check("ld_pc", ex_pc, 64'h100);
      check("ld_valid", 64'(ex_valid), 64'd1);
      id_add(5'd7, 5'd5, 5'd6);
      #1 check("lu_hazard", 64'(hazard_stall), 64'd1);
      tick();
      check("bubble_valid", 64'(ex_valid), 64'd0);
      check("bubble_regwrite", 64'(ex_RegWrite), 64'd0);
      check("bubble_pc", ex_pc, 64'd0);
      check("bubble_hazard_drop", 64'(hazard_stall), 64'd0);
      tick();
      check("use_rs1", 64'(ex_rs1), 64'd5);
      check("use_aluop", 64'(ex_ALUOp), 64'(2'b10));
      check("use_rd1", ex_rd1, 64'hAAAA);
      check("use_regwrite", 64'(ex_RegWrite), 64'd1);

      // Load to x0: no hazard for the following store on rs2=0
      id_ld(5'd0, 5'd1);
      tick();
      check("ldx0_regwrite", 64'(ex_RegWrite), 64'd0);
      id_sd(5'd3, 5'd0);
      #1 check("sd_x0_hazard", 64'(hazard_stall), 64'd0);
      tick();
      check("sd_memwrite", 64'(ex_MemWrite), 64'd1);
      check("sd_funct4", 64'(ex_funct4), 64'h3);

      // Store reads rs2 even though ALUSrc=1; addi does not read rs2
      id_ld(5'd6, 5'd1);
      tick();
      id_sd(5'd3, 5'd6);
      #1 check("sd_rs2_hazard", 64'(hazard_stall), 64'd1);
      id_addi(5'd9, 5'd1, 64'h4);
      id_rs2 = 5'd6;
      #1 check("addi_rs2_nohazard", 64'(hazard_stall), 64'd0);
      id_valid = 0;
      #1 check("invalid_id_nohazard", 64'(hazard_stall), 64'd0);

      // addi x0 loaded: RegWrite forced off
      id_addi(5'd0, 5'd1, 64'h4);
      tick();
      check("addi0_regwrite", 64'(ex_RegWrite), 64'd0);
      check("addi0_alusrc", 64'(ex_ALUSrc), 64'd1);
      check("addi0_valid", 64'(ex_valid), 64'd1);

      // stall_in held for three cycles: EX contents frozen
      id_addi(5'd7, 5'd1, 64'h10);
      tick();
      id_add(5'd11, 5'd12, 5'd13);
      stall_in = 1;
      #1 check("stall_hazard", 64'(hazard_stall), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_imm", ex_imm, 64'h10);
         check("stall_rd", 64'(ex_rd), 64'd7);
      end
      stall_in = 0;

      // beq in EX, then flush and stall_in together: flush wins
      clear_id(); id_valid = 1; Branch = 1; ALUOp = 2'b01; id_rs1 = 1; id_rs2 = 2;
      id_pc = 64'h200;
      tick();
      check("beq_aluop", 64'(ex_ALUOp), 64'(2'b01));
      check("beq_branch", 64'(ex_Branch), 64'd1);
      id_add(5'd8, 5'd1, 5'd2);
      flush = 1; stall_in = 1;
      tick();
      check("flush_branch", 64'(ex_Branch), 64'd0);
      check("flush_aluop", 64'(ex_ALUOp), 64'd0);
      check("flush_valid", 64'(ex_valid), 64'd0);
      check("flush_pc", ex_pc, 64'd0);
      flush = 0; stall_in = 0;

      // id_valid=0 load: controls cleared, data still captured
      id_addi(5'd4, 5'd1, 64'h55);
      id_valid = 0;
      tick();
      check("inv_valid", 64'(ex_valid), 64'd0);
      check("inv_regwrite", 64'(ex_RegWrite), 64'd0);
      check("inv_aluop", 64'(ex_ALUOp), 64'd0);
      check("inv_imm", ex_imm, 64'h55);

      // Reset pulsed between edges while EX holds a stalled sd
      id_sd(5'd3, 5'd4);
      tick();
      check("pre_rst_memwrite", 64'(ex_MemWrite), 64'd1);
      stall_in = 1;
      #2 reset = 1;
      #1 check("async_rst_memwrite", 64'(ex_MemWrite), 64'd0);
      check("async_rst_pc", ex_pc, 64'd0);
      #1 reset = 0;
      stall_in = 0;

      // Two load-use bubbles, then one flush
      id_ld(5'd5, 5'd2);
      tick();
      id_add(5'd7, 5'd5, 5'd0);
      tick();
      tick();
      id_ld(5'd9, 5'd2);
      tick();
      id_add(5'd10, 5'd1, 5'd9);
      tick();
      check("bubble2_valid", 64'(ex_valid), 64'd0);
      tick();
      check("after_bubble2_rd", 64'(ex_rd), 64'd10);
      flush = 1;
      tick();
      flush = 0;
`ifdef ID_EX_PERF_EN
      check("perf_bubbles", 64'(perf_bubbles), 64'd2);
      check("perf_flushes", 64'(perf_flushes), 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
